id_issue_queue: RTL and testbench
=================================

Name: id_issue_queue

Overview:
- Parametrised decode/issue buffer between fetch and execute in the MIPS pipeline.
- Holds up to DEPTH fetched instructions together with their PC and fetch-exception info.
- Classifies the head entry for SYSCALL, BREAK and reserved-instruction exceptions.
- Applies load-use hazard stalls over a configurable load latency, and issues the head through a valid/ready handshake.
- Stops issuing after an exception until the pipeline is flushed.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- LOAD_LAT, 1, load-use distance: 1 checks EX only; 2 checks EX and MEM.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- in_valid  in  1  fetch entry valid
- in_ready  out  1  queue can accept
- in_ins  in  32  instruction word
- in_pc  in  32  instruction PC
- in_exc  in  1  fetch-side exception already raised
- in_exccode  in  5  fetch exception code
- in_badvaddr  in  32  fetch bad address
- out_valid  out  1  head issuable this cycle
- out_ready  in  1  execute accepts
- out_ins  out  32  head instruction
- out_pc  out  32  head PC
- out_exc  out  1  head carries an exception
- out_exccode  out  5  final exception code
- out_badvaddr  out  32  final bad address (0 for decode-generated exceptions)
- ex_memread  in  1  EX holds a load
- ex_rw  in  5  EX destination register
- mem_memread  in  1  MEM holds a load
- mem_rw  in  5  MEM destination register
- ex_exc  in  1  older exception in EX
- mem_exc  in  1  older exception in MEM
- flush  in  1  exception/ERET redirect
- stall_cnt  out  CNT_W  hazard-stall cycles

Behaviour:
- Reset, synchronous, active high; same effect mid-operation:
  - count=0, read/write pointers=0, state=RUN, stall_cnt=0.
  - out_valid=0. in_ready=1 from the first cycle after reset.
  - All out_* data ports=0 while the queue is empty.
- Storage:
  - Circular buffer with pointer wrap at DEPTH.
  - in_ready = (count<DEPTH) && !flush. No write-through bypass.
  - An entry pushed in cycle N is at the head no earlier than N+1.
- Push / pop:
  - Push on in_valid&&in_ready.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pop when full frees a slot; in_ready reflects it next cycle.
- Flush:
  - Highest priority: pointers and count return to 0 and state returns to RUN next cycle.
  - A push and a pop in the same cycle as flush are both discarded.
- Exception classification of the head, priority order:
  - in_exc → pass in_exccode and in_badvaddr unchanged.
  - SYSCALL (op 0, func 0x0C) → code 0x08.
  - BREAK (op 0, func 0x0D) → code 0x09.
  - Opcode/func not in the supported set → code 0x0A (RI).
  - Otherwise out_exc=0, out_exccode=0, out_badvaddr=0.
- Hazard stall, hz=1 when any of:
  - ex_memread && ex_rw!=0 && ex_rw matches a source the head reads.
  - LOAD_LAT==2 and the same test holds on mem_memread/mem_rw.
  - ex_exc||mem_exc: an older exception is in flight.
- Source-use rules:
  - rs is used unless the instruction is a shift-by-immediate, J/JAL, or a CP0 move.
  - rt is used for R-type, BEQ/BNE, stores and MTC0.
- out_valid = count!=0 && !hz && state==RUN.
- stall_cnt increments by 1 each cycle count!=0 && hz, saturating at all-ones. It is not cleared by flush.
- State machine:
  - RUN → BLOCK when an entry with out_exc=1 is popped.
  - BLOCK: out_valid=0; pushes are still accepted while space remains.
  - BLOCK → RUN on flush only.
- out_* data ports are driven combinationally from the head entry regardless of out_valid.

Decomposition:
- Shared package id_pkg holds:
  - Opcode and func constants.
  - Exception codes EXC_SYS=0x08, EXC_BP=0x09, EXC_RI=0x0A.
  - Pure functions uses_rs(ins), uses_rt(ins), is_legal(ins).
- One sub-module, id_exc_classify: combinational head classification producing exc, code and badvaddr.
- Queue storage, pointers, state machine and counter stay in the top module.

Test Plan:
- Push 4 ADDU (DEPTH=4) with out_ready=0 → in_ready=0 after the 4th push. Set out_ready=1 → issued in order; PCs 0x00,0x04,0x08,0x0C.
- Head ADDU rs=5, ex_memread=1, ex_rw=5 for 1 cycle → out_valid=0 that cycle, stall_cnt=1, then issues. Repeat with ex_rw=0 → no stall.
- LOAD_LAT=2, mem_memread=1, mem_rw=7, head SW rt=7 → stalled. Same stimulus with LOAD_LAT=1 → issues immediately.
- Head ins 0x0000000C → out_exc=1, code 0x08, badvaddr 0. After the pop, following entries are held (out_valid=0) until flush; queue is then empty and in RUN.
- Head with in_exc=1, code 0x04, badvaddr 0x0000_0003, and an illegal opcode 0x3F → code 0x04 and badvaddr 0x3 pass through. Without in_exc → code 0x0A.
- Full queue with push, pop and flush asserted together → count=0 next cycle, no issue. rst mid-operation → all outputs at reset values next cycle.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants and instruction-field helpers for the ID issue queue.
package id_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_BREAK   = 6'h0D;

  localparam logic [4:0] CP0_MF = 5'h00;
  localparam logic [4:0] CP0_MT = 5'h04;
  localparam logic [31:0] INS_ERET = 32'h4200_0018;

  localparam logic [4:0] EXC_SYS = 5'h08;
  localparam logic [4:0] EXC_BP  = 5'h09;
  localparam logic [4:0] EXC_RI  = 5'h0A;

  typedef enum logic {ST_RUN, ST_BLOCK} iq_state_t;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } iq_entry_t;

  function automatic logic uses_rs(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    return !((op == OP_SPECIAL && fn inside {FN_SLL, FN_SRL, FN_SRA}) ||
             op inside {OP_J, OP_JAL} || op == OP_COP0);
  endfunction

  function automatic logic uses_rt(input logic [31:0] ins);
    logic [5:0] op;
    op = ins[31:26];
    return op == OP_SPECIAL || op inside {OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW} ||
           (op == OP_COP0 && ins[25:21] == CP0_MT);
  endfunction

  // Supported set: MIPS-I integer core plus MFC0/MTC0/ERET.
  function automatic logic is_legal(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == OP_SPECIAL)
      return fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                        6'h0C, 6'h0D, [6'h10:6'h13], [6'h18:6'h1B], [6'h20:6'h27],
                        6'h2A, 6'h2B};
    if (op == OP_REGIMM)
      return ins[20:16] inside {5'h00, 5'h01, 5'h10, 5'h11};
    if (op == OP_COP0)
      return ins[25:21] == CP0_MF || ins[25:21] == CP0_MT || ins == INS_ERET;
    return op inside {[6'h02:6'h0F], 6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
                      OP_SB, OP_SH, OP_SW};
  endfunction

  // Head reads register rw as a source (r0 never creates a dependency).
  function automatic logic src_hit(input logic [31:0] ins, input logic [4:0] rw);
    return rw != 5'd0 && ((uses_rs(ins) && ins[25:21] == rw) ||
                          (uses_rt(ins) && ins[20:16] == rw));
  endfunction

endpackage

// File: rtl/id_exc_classify.sv
// Combinational exception classification of the queue head.
module id_exc_classify
  import id_pkg::*;
(
  input  logic [31:0] ins,
  input  logic        fe_exc,
  input  logic [4:0]  fe_exccode,
  input  logic [31:0] fe_badvaddr,
  output logic        exc,
  output logic [4:0]  exccode,
  output logic [31:0] badvaddr
);

  always_comb begin
    exc      = 1'b0;
    exccode  = 5'd0;
    badvaddr = 32'd0;
    if (fe_exc) begin
      exc      = 1'b1;
      exccode  = fe_exccode;
      badvaddr = fe_badvaddr;
    end else if (ins[31:26] == OP_SPECIAL && ins[5:0] == FN_SYSCALL) begin
      exc     = 1'b1;
      exccode = EXC_SYS;
    end else if (ins[31:26] == OP_SPECIAL && ins[5:0] == FN_BREAK) begin
      exc     = 1'b1;
      exccode = EXC_BP;
    end else if (!is_legal(ins)) begin
      exc     = 1'b1;
      exccode = EXC_RI;
    end
  end

endmodule

// File: rtl/id_issue_queue.sv
// Decode/issue buffer: circular queue with head classification, load-use stall and exception blocking.
module id_issue_queue
  import id_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [31:0]      in_pc,
  input  logic             in_exc,
  input  logic [4:0]       in_exccode,
  input  logic [31:0]      in_badvaddr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_ins,
  output logic [31:0]      out_pc,
  output logic             out_exc,
  output logic [4:0]       out_exccode,
  output logic [31:0]      out_badvaddr,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rw,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rw,
  input  logic             ex_exc,
  input  logic             mem_exc,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int PW = $clog2(DEPTH);

  iq_entry_t   mem [DEPTH];
  iq_entry_t   head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  iq_state_t   state, state_nxt;
  logic        hz, push, pop, nonempty;

  assign nonempty = count != '0;
  // Empty queue presents an all-zero entry so out_* read as zero.
  assign head = nonempty ? mem[rd_ptr] : '0;

  id_exc_classify u_cls (
    .ins         (head.ins),
    .fe_exc      (head.exc),
    .fe_exccode  (head.exccode),
    .fe_badvaddr (head.badvaddr),
    .exc         (out_exc),
    .exccode     (out_exccode),
    .badvaddr    (out_badvaddr)
  );

  assign hz = (ex_memread && src_hit(head.ins, ex_rw)) ||
              ((LOAD_LAT >= 2) && mem_memread && src_hit(head.ins, mem_rw)) ||
              ex_exc || mem_exc;

  assign in_ready  = (count < (PW+1)'(DEPTH)) && !flush;
  assign out_valid = nonempty && !hz && state == ST_RUN;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_ins   = head.ins;
  assign out_pc    = head.pc;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{in_ins, in_pc, in_exc, in_exccode, in_badvaddr};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
    end else begin
      if (nonempty && hz && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)                                   state_nxt = ST_RUN;
    else if (state == ST_RUN && pop && out_exc)  state_nxt = ST_BLOCK;
  end

endmodule

// File: tb/tb_id_issue_queue.sv
// Directed scoreboard bench for id_issue_queue; dut1 uses LOAD_LAT=1, dut2 LOAD_LAT=2 on shared stimulus.
module tb_id_issue_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_exc, out_ready, ex_memread, mem_memread, ex_exc, mem_exc, flush;
  logic [31:0] in_ins, in_pc, in_badvaddr;
  logic [4:0]  in_exccode, ex_rw, mem_rw;

  logic        o1_in_ready, o1_out_valid, o1_out_exc;
  logic [31:0] o1_out_ins, o1_out_pc, o1_out_badvaddr;
  logic [4:0]  o1_out_exccode;
  logic [15:0] o1_stall;
  logic        o2_in_ready, o2_out_valid, o2_out_exc;
  logic [31:0] o2_out_ins, o2_out_pc, o2_out_badvaddr;
  logic [4:0]  o2_out_exccode;
  logic [15:0] o2_stall;

  id_issue_queue #(.DEPTH(4), .LOAD_LAT(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o1_in_ready), .in_ins(in_ins),
    .in_pc(in_pc), .in_exc(in_exc), .in_exccode(in_exccode), .in_badvaddr(in_badvaddr),
    .out_valid(o1_out_valid), .out_ready(out_ready), .out_ins(o1_out_ins), .out_pc(o1_out_pc),
    .out_exc(o1_out_exc), .out_exccode(o1_out_exccode), .out_badvaddr(o1_out_badvaddr),
    .ex_memread(ex_memread), .ex_rw(ex_rw), .mem_memread(mem_memread), .mem_rw(mem_rw),
    .ex_exc(ex_exc), .mem_exc(mem_exc), .flush(flush), .stall_cnt(o1_stall));

  id_issue_queue #(.DEPTH(4), .LOAD_LAT(2), .CNT_W(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(o2_in_ready), .in_ins(in_ins),
    .in_pc(in_pc), .in_exc(in_exc), .in_exccode(in_exccode), .in_badvaddr(in_badvaddr),
    .out_valid(o2_out_valid), .out_ready(out_ready), .out_ins(o2_out_ins), .out_pc(o2_out_pc),
    .out_exc(o2_out_exc), .out_exccode(o2_out_exccode), .out_badvaddr(o2_out_badvaddr),
    .ex_memread(ex_memread), .ex_rw(ex_rw), .mem_memread(mem_memread), .mem_rw(mem_rw),
    .ex_exc(ex_exc), .mem_exc(mem_exc), .flush(flush), .stall_cnt(o2_stall));

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] bad;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_st1 = 0;
  int   exp_st2 = 0;

  localparam logic [31:0] ADDU    = 32'h0022_1821; // addu r3,r1,r2
  localparam logic [31:0] ADDU_R5 = 32'h00A0_1821; // addu r3,r5,r0
  localparam logic [31:0] SW_R7   = 32'hAC07_0000; // sw r7,0(r0)
  localparam logic [31:0] SYSCALL = 32'h0000_000C;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("%s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; at the negedge any issue from dut1 is scored against the queue.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (!rst && !flush && o1_out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_issue_pc", o1_out_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("issue_pc", o1_out_pc, e.pc);
        chk("issue_ins", o1_out_ins, e.ins);
        chk("issue_exc", {31'd0, o1_out_exc}, {31'd0, e.exc});
        chk("issue_code", {27'd0, o1_out_exccode}, {27'd0, e.code});
        chk("issue_bad", o1_out_badvaddr, e.bad);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc, input logic ie,
                      input logic [4:0] ic, input logic [31:0] ib, input logic ee,
                      input logic [4:0] ec, input logic [31:0] eb);
    in_valid = 1'b1; in_ins = ins; in_pc = pc;
    in_exc = ie; in_exccode = ic; in_badvaddr = ib;
    #1;
    chk("push_ready", {31'd0, o1_in_ready}, 32'd1);
    sb.push_back('{ins, pc, ee, ec, eb});
    tick();
    in_valid = 1'b0; in_exc = 1'b0; in_exccode = '0; in_badvaddr = '0;
    #1;
  endtask

  task automatic push_ok(input logic [31:0] ins, input logic [31:0] pc);
    push(ins, pc, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
    chk(tag, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_exc = 0; out_ready = 0; ex_memread = 0; mem_memread = 0;
    ex_exc = 0; mem_exc = 0; flush = 0; in_ins = 0; in_pc = 0; in_badvaddr = 0;
    in_exccode = 0; ex_rw = 0; mem_rw = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", {31'd0, o1_out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, o1_in_ready}, 32'd1);
    chk("rst_stall", {16'd0, o1_stall}, 32'd0);
    chk("rst_out_pc", o1_out_pc, 32'd0);
    chk("rst_out_ins", o1_out_ins, 32'd0);
    chk("rst_out_code", {27'd0, o1_out_exccode}, 32'd0);

    // Fill to full, then drain in order.
    for (int i = 0; i < 4; i++) push_ok(ADDU, 32'(i * 4));
    chk("full_in_ready", {31'd0, o1_in_ready}, 32'd0);
    chk("full_head_pc", o1_out_pc, 32'h0);
    out_ready = 1'b1; #1;
    chk("pop_full_in_ready", {31'd0, o1_in_ready}, 32'd0);
    tick();
    chk("after_pop_in_ready", {31'd0, o1_in_ready}, 32'd1);
    drain("drain_fill");
    out_ready = 1'b0; #1;

    // Load-use on EX.
    push_ok(ADDU_R5, 32'h10);
    ex_memread = 1'b1; ex_rw = 5'd5; out_ready = 1'b1; #1;
    chk("ex_hz_valid", {31'd0, o1_out_valid}, 32'd0);
    tick(); exp_st1++; exp_st2++;
    ex_memread = 1'b0; #1;
    chk("ex_hz_stall", {16'd0, o1_stall}, 32'(exp_st1));
    chk("ex_hz_release", {31'd0, o1_out_valid}, 32'd1);
    tick();
    out_ready = 1'b0; #1;
    push_ok(ADDU_R5, 32'h14);
    ex_memread = 1'b1; ex_rw = 5'd0; out_ready = 1'b1; #1;
    chk("ex_r0_valid", {31'd0, o1_out_valid}, 32'd1);
    tick();
    ex_memread = 1'b0; #1;
    chk("ex_r0_stall", {16'd0, o1_stall}, 32'(exp_st1));
    chk("empty_valid", {31'd0, o1_out_valid}, 32'd0);
    out_ready = 1'b0; #1;

    // Older exception in flight.
    push_ok(ADDU, 32'h18);
    ex_exc = 1'b1; out_ready = 1'b1; #1;
    chk("ex_exc_valid", {31'd0, o1_out_valid}, 32'd0);
    tick(); exp_st1++; exp_st2++;
    ex_exc = 1'b0; #1;
    chk("ex_exc_release", {31'd0, o1_out_valid}, 32'd1);
    tick();
    out_ready = 1'b0; #1;

    // MEM load-use: only the LOAD_LAT=2 instance stalls.
    push_ok(SW_R7, 32'h1C);
    mem_memread = 1'b1; mem_rw = 5'd7; #1;
    chk("mem_hz_lat2", {31'd0, o2_out_valid}, 32'd0);
    chk("mem_hz_lat1", {31'd0, o1_out_valid}, 32'd1);
    tick(); exp_st2++;
    mem_memread = 1'b0; out_ready = 1'b1; #1;
    chk("mem_stall_lat2", {16'd0, o2_stall}, 32'(exp_st2));
    chk("mem_stall_lat1", {16'd0, o1_stall}, 32'(exp_st1));
    tick();
    drain("drain_mem");
    out_ready = 1'b0; #1;

    // SYSCALL blocks further issue until flush.
    push(SYSCALL, 32'h20, 1'b0, 5'd0, 32'd0, 1'b1, 5'h08, 32'd0);
    push_ok(ADDU, 32'h24);
    chk("sys_exc", {31'd0, o1_out_exc}, 32'd1);
    chk("sys_code", {27'd0, o1_out_exccode}, 32'h08);
    chk("sys_bad", o1_out_badvaddr, 32'd0);
    out_ready = 1'b1; #1;
    tick();
    chk("block_valid", {31'd0, o1_out_valid}, 32'd0);
    chk("block_head_pc", o1_out_pc, 32'h24);
    tick();
    chk("block_valid2", {31'd0, o1_out_valid}, 32'd0);
    push_ok(ADDU, 32'h28);
    chk("block_push_held", {31'd0, o1_out_valid}, 32'd0);
    flush = 1'b1; tick(); flush = 1'b0; sb.delete(); #1;
    chk("flush_valid", {31'd0, o1_out_valid}, 32'd0);
    chk("flush_pc", o1_out_pc, 32'd0);
    chk("flush_in_ready", {31'd0, o1_in_ready}, 32'd1);
    push_ok(ADDU, 32'h2C);
    drain("drain_after_flush");
    out_ready = 1'b0; #1;

    // Fetch exception passes through ahead of RI.
    push(ILLEGAL, 32'h30, 1'b1, 5'h04, 32'h3, 1'b1, 5'h04, 32'h3);
    chk("fe_code", {27'd0, o1_out_exccode}, 32'h04);
    chk("fe_bad", o1_out_badvaddr, 32'h3);
    flush = 1'b1; tick(); flush = 1'b0; sb.delete(); #1;
    push(ILLEGAL, 32'h34, 1'b0, 5'd0, 32'd0, 1'b1, 5'h0A, 32'd0);
    chk("ri_code", {27'd0, o1_out_exccode}, 32'h0A);
    chk("ri_bad", o1_out_badvaddr, 32'd0);
    out_ready = 1'b1; #1;
    tick();
    chk("ri_block", {31'd0, o1_out_valid}, 32'd0);
    out_ready = 1'b0; flush = 1'b1; tick(); flush = 1'b0; sb.delete(); #1;

    // Push, pop and flush together: full case, then a case with room.
    for (int i = 0; i < 4; i++) push_ok(ADDU, 32'h40 + 32'(i * 4));
    in_valid = 1'b1; in_ins = ADDU; in_pc = 32'h50; out_ready = 1'b1; flush = 1'b1; #1;
    chk("flush_blocks_push", {31'd0, o1_in_ready}, 32'd0);
    tick();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; sb.delete(); #1;
    chk("ppf_full_valid", {31'd0, o1_out_valid}, 32'd0);
    chk("ppf_full_pc", o1_out_pc, 32'd0);
    push_ok(ADDU, 32'h54);
    push_ok(ADDU, 32'h58);
    in_valid = 1'b1; in_ins = ADDU_R5; in_pc = 32'h5C; out_ready = 1'b1; flush = 1'b1; #1;
    tick();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; sb.delete(); #1;
    chk("ppf_part_valid", {31'd0, o1_out_valid}, 32'd0);
    chk("ppf_part_ins", o1_out_ins, 32'd0);
    chk("stall_kept_over_flush", {16'd0, o1_stall}, 32'(exp_st1));

    // Reset mid-operation.
    push_ok(ADDU, 32'h60);
    push_ok(ADDU, 32'h64);
    ex_memread = 1'b1; ex_rw = 5'd1; tick();
    ex_memread = 1'b0; rst = 1'b1; tick(); rst = 1'b0; sb.delete(); #1;
    chk("mid_rst_valid", {31'd0, o1_out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, o1_in_ready}, 32'd1);
    chk("mid_rst_stall1", {16'd0, o1_stall}, 32'd0);
    chk("mid_rst_stall2", {16'd0, o2_stall}, 32'd0);
    chk("mid_rst_pc", o1_out_pc, 32'd0);
    chk("mid_rst_ins", o2_out_ins, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
